// File: rtl/park_pkg.sv
// Shared definitions for the Park transform blocks: FSM state encoding, default widths,
// and the saturating fit used when FORWARD_PARK_SAT_EN is defined.
package park_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_P0,
        S_P1,
        S_P2,
        S_P3,
        S_OUT
    } park_state_t;

    localparam int PARK_D_WIDTH = 32;
    localparam int PARK_Q_BITS  = 10;
    // saturate() works on a sign-extended copy wide enough for any D_WIDTH up to PARK_MAX_W
    localparam int PARK_MAX_W   = 64;
    localparam int PARK_EXT_W   = 2 * PARK_MAX_W + 1;

    function automatic logic signed [PARK_EXT_W-1:0] saturate(
        input  logic signed [PARK_EXT_W-1:0] x,
        input  int unsigned                  w,
        output logic                         clipped
    );
        logic signed [PARK_EXT_W-1:0] hi;
        logic signed [PARK_EXT_W-1:0] lo;
        hi      = (PARK_EXT_W'(1) <<< (w - 1)) - PARK_EXT_W'(1);
        lo      = ~hi;
        clipped = (x > hi) || (x < lo);
        if (x > hi)      return hi;
        else if (x < lo) return lo;
        else             return x;
    endfunction

endpackage

// File: rtl/park_mac.sv
// Single signed multiplier feeding two selectable accumulators (load / add / sub).
// The caller time-multiplexes the operands so only one multiplier is ever built.
module park_mac
    import park_pkg::*;
#(
    parameter int D_WIDTH = PARK_D_WIDTH
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic signed [D_WIDTH-1:0] a,
    input  logic signed [D_WIDTH-1:0] b,
    input  logic                     load,
    input  logic                     add,
    input  logic                     sub,
    input  logic                     acc_sel,
    output logic signed [2*D_WIDTH:0] acc0,
    output logic signed [2*D_WIDTH:0] acc1
);

    localparam int PROD_W = 2 * D_WIDTH;
    localparam int ACC_W  = 2 * D_WIDTH + 1;

    logic signed [PROD_W-1:0] a_x;
    logic signed [PROD_W-1:0] b_x;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_x;
    logic signed [ACC_W-1:0]  acc_cur;
    logic signed [ACC_W-1:0]  acc_nxt;
    logic                     acc_we;

    assign a_x    = PROD_W'(a);
    assign b_x    = PROD_W'(b);
    assign prod   = a_x * b_x;
    assign prod_x = ACC_W'(prod);

    assign acc_cur = acc_sel ? acc1 : acc0;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        acc_nxt = acc_cur;
        acc_we  = 1'b0;
        if (load) begin
            acc_nxt = prod_x;
            acc_we  = 1'b1;
        end else if (add) begin
            acc_nxt = acc_cur + prod_x;
            acc_we  = 1'b1;
        end else if (sub) begin
            acc_nxt = acc_cur - prod_x;
            acc_we  = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            acc0 <= '0;
            acc1 <= '0;
        end else if (acc_we) begin
            if (acc_sel) acc1 <= acc_nxt;
            else         acc0 <= acc_nxt;
        end
    end

endmodule

// File: rtl/forward_park.sv
// Forward Park transform: d = alpha*cos + beta*sin, q = beta*cos - alpha*sin, on one shared MAC.
// Define FORWARD_PARK_SAT_EN to saturate d/q instead of wrapping and to add the sat output.
module forward_park
    import park_pkg::*;
#(
    parameter int D_WIDTH = PARK_D_WIDTH,
    parameter int Q_BITS  = PARK_Q_BITS
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic signed [D_WIDTH-1:0] alpha,
    input  logic signed [D_WIDTH-1:0] beta,
    input  logic signed [D_WIDTH-1:0] sin,
    input  logic signed [D_WIDTH-1:0] cos,
    input  logic                      start,
    output logic                      busy,
    output logic signed [D_WIDTH-1:0] d,
    output logic signed [D_WIDTH-1:0] q,
`ifdef FORWARD_PARK_SAT_EN
    output logic                      sat,
`endif
    output logic                      done
);

    localparam int ACC_W = 2 * D_WIDTH + 1;

    park_state_t state, state_nxt;

    logic signed [D_WIDTH-1:0] alpha_r, beta_r, sin_r, cos_r;
    logic signed [D_WIDTH-1:0] mac_a, mac_b;
    logic                      mac_load, mac_add, mac_sub, mac_sel;
    logic signed [ACC_W-1:0]   acc_d, acc_q;
    logic signed [D_WIDTH-1:0] d_fit, q_fit;

    park_mac #(.D_WIDTH(D_WIDTH)) u_mac (
        .clk     (clk),
        .rstb    (rstb),
        .a       (mac_a),
        .b       (mac_b),
        .load    (mac_load),
        .add     (mac_add),
        .sub     (mac_sub),
        .acc_sel (mac_sel),
        .acc0    (acc_d),
        .acc1    (acc_q)
    );

`ifdef FORWARD_PARK_SAT_EN
    logic d_clip, q_clip;
    always_comb begin
        d_fit = D_WIDTH'(saturate(PARK_EXT_W'(acc_d >>> Q_BITS), D_WIDTH, d_clip));
        q_fit = D_WIDTH'(saturate(PARK_EXT_W'(acc_q >>> Q_BITS), D_WIDTH, q_clip));
    end
`else
    assign d_fit = D_WIDTH'(acc_d >>> Q_BITS);
    assign q_fit = D_WIDTH'(acc_q >>> Q_BITS);
`endif

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rstb) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Sequence: acc_d = a*c, += b*s; acc_q = b*c, -= a*s; then publish.
    always_comb begin
        state_nxt = state;
        mac_a     = alpha_r;
        mac_b     = cos_r;
        mac_load  = 1'b0;
        mac_add   = 1'b0;
        mac_sub   = 1'b0;
        mac_sel   = 1'b0;
        unique case (state)
            S_IDLE: if (start) state_nxt = S_P0;
            S_P0: begin
                mac_load  = 1'b1;
                state_nxt = S_P1;
            end
            S_P1: begin
                mac_a     = beta_r;
                mac_b     = sin_r;
                mac_add   = 1'b1;
                state_nxt = S_P2;
            end
            S_P2: begin
                mac_a     = beta_r;
                mac_load  = 1'b1;
                mac_sel   = 1'b1;
                state_nxt = S_P3;
            end
            S_P3: begin
                mac_b     = sin_r;
                mac_sub   = 1'b1;
                mac_sel   = 1'b1;
                state_nxt = S_OUT;
            end
            S_OUT:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            alpha_r <= '0;
            beta_r  <= '0;
            sin_r   <= '0;
            cos_r   <= '0;
            d       <= '0;
            q       <= '0;
            done    <= 1'b0;
`ifdef FORWARD_PARK_SAT_EN
            sat     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (state == S_IDLE && start) begin
                alpha_r <= alpha;
                beta_r  <= beta;
                sin_r   <= sin;
                cos_r   <= cos;
            end
            if (state == S_OUT) begin
                d    <= d_fit;
                q    <= q_fit;
                done <= 1'b1;
`ifdef FORWARD_PARK_SAT_EN
                sat  <= d_clip | q_clip;
`endif
            end
        end
    end

endmodule

// File: tb/tb_forward_park.sv
// Directed bench for forward_park: reset, rotations, floor, overflow, ignored start, abort.
module tb_forward_park;

    logic               clk   = 1'b0;
    logic               rstb  = 1'b0;
    logic               start = 1'b0;
    logic signed [31:0] alpha = '0;
    logic signed [31:0] beta  = '0;
    logic signed [31:0] sin_v = '0;
    logic signed [31:0] cos_v = '0;
    logic               busy;
    logic               done;
    logic signed [31:0] d;
    logic signed [31:0] q;
`ifdef FORWARD_PARK_SAT_EN
    logic               sat;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    forward_park dut (
        .clk   (clk),
        .rstb  (rstb),
        .alpha (alpha),
        .beta  (beta),
        .sin   (sin_v),
        .cos   (cos_v),
        .start (start),
        .busy  (busy),
        .d     (d),
        .q     (q),
`ifdef FORWARD_PARK_SAT_EN
        .sat   (sat),
`endif
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        else             n_pass++;
    endtask

    // mode 0: plain; 1: extra start while busy; 2: scramble inputs while busy
    task automatic run_xform(input string tag,
                             input logic signed [31:0] a, input logic signed [31:0] b,
                             input logic signed [31:0] s, input logic signed [31:0] c,
                             input logic signed [31:0] exp_d, input logic signed [31:0] exp_q,
                             input logic exp_sat, input int mode);
        int n_done;
        alpha = a;
        beta  = b;
        sin_v = s;
        cos_v = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check({tag, ".busy"}, busy, 1);
            check({tag, ".done_early"}, done, 0);
            if (mode == 1 && i == 2) start = 1'b1;
            if (mode == 2 && i == 1) begin
                alpha = $urandom;
                beta  = $urandom;
                sin_v = $urandom;
                cos_v = $urandom;
            end
            tick();
            start = 1'b0;
        end
        check({tag, ".done"}, done, 1);
        check({tag, ".busy_end"}, busy, 0);
        check({tag, ".d"}, d, exp_d);
        check({tag, ".q"}, q, exp_q);
`ifdef FORWARD_PARK_SAT_EN
        check({tag, ".sat"}, sat, exp_sat);
`else
        if (exp_sat) check({tag, ".sat_unexpected"}, 0, 0);
`endif
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) n_done++;
        end
        check({tag, ".extra_done"}, n_done, 0);
        check({tag, ".d_hold"}, d, exp_d);
        check({tag, ".q_hold"}, q, exp_q);
    endtask

    initial begin
        int n_done;

        // Reset with start held high
        alpha = 1000;
        beta  = -500;
        cos_v = 1024;
        sin_v = 0;
        start = 1'b1;
        rstb  = 1'b0;
        tick();
        tick();
        check("rst.d", d, 0);
        check("rst.q", q, 0);
        check("rst.done", done, 0);
        check("rst.busy", busy, 0);
        rstb = 1'b1;

        run_xform("theta0", 1000, -500, 0, 1024, 1000, -500, 1'b0, 0);
        run_xform("theta90", 1000, -500, 1024, 0, -500, -1000, 1'b0, 1);
        run_xform("floor", -3, 0, 0, 512, -2, 0, 1'b0, 2);
`ifdef FORWARD_PARK_SAT_EN
        run_xform("ovf", 32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 1024, 1024, 32'sh7FFF_FFFF, 0, 1'b1, 0);
`else
        run_xform("ovf", 32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 1024, 1024, -2, 0, 1'b0, 0);
`endif

        // Abort in S_P2
        alpha = 1000;
        beta  = -500;
        sin_v = 0;
        cos_v = 1024;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("abort.busy_pre", busy, 1);
        rstb = 1'b0;
        tick();
        rstb = 1'b1;
        check("abort.d", d, 0);
        check("abort.q", q, 0);
        check("abort.done", done, 0);
        check("abort.busy", busy, 0);
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) n_done++;
        end
        check("abort.no_done", n_done, 0);

        run_xform("fresh", 1000, -500, 1024, 0, -500, -1000, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
